// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch squash and a
// fixed-length mult/div front-end stall, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        md_start,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_busy,
  output logic [15:0] stall_count
);

  localparam int unsigned MdCntW = 7;
  localparam int unsigned StallW = 16;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MDWAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [MdCntW-1:0]   md_cnt_q, md_cnt_d;
  logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
  logic                luhaz;

  // Load in EX writes a register the ID instruction reads ($zero never hazards)
  assign luhaz = ex_memread & (ex_rt != 5'd0) &
                 ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));

  assign stall_count = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_busy     = 1'b0;

    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
    end else begin
      unique case (state_q)
        RUN, LDSTALL: begin
          // LDSTALL already has a bubble in EX, so the hazard is gone
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = RUN;
          end else if (luhaz && (state_q == RUN)) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            state_d     = LDSTALL;
          end else if (md_start) begin
            state_d  = MDWAIT;
            md_cnt_d = MdCntW'(MD_LAT - 1);
          end else begin
            state_d = RUN;
          end
        end
        MDWAIT: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          md_busy     = 1'b1;
          if (md_cnt_q == '0) begin
            state_d = RUN;
          end else begin
            md_cnt_d = md_cnt_q - MdCntW'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (!rst && !pc_en && (stall_cnt_q != {StallW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + StallW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: table of input/expected-output vectors fed through
// a scoreboard queue, plus a long mult/div run for stall counter saturation.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst2;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, ex_memread, branch_taken, md_start, md_start2;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, md_busy;
  logic [15:0] stall_count;
  logic        pc_en2, ifid_en2, ifid_flush2, idex_bubble2, md_busy2;
  logic [15:0] stall_count2;

  pipe_hazard_ctrl #(.MD_LAT(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .md_start(md_start), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .md_busy(md_busy),
    .stall_count(stall_count)
  );

  pipe_hazard_ctrl #(.MD_LAT(64)) dut64 (
    .clk(clk), .rst(rst2), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .md_start(md_start2), .pc_en(pc_en2), .ifid_en(ifid_en2),
    .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2), .md_busy(md_busy2),
    .stall_count(stall_count2)
  );

  // Expected {pc_en, ifid_en, ifid_flush, idex_bubble, md_busy}
  localparam logic [4:0] N = 5'b11000;
  localparam logic [4:0] S = 5'b00010;
  localparam logic [4:0] B = 5'b11110;
  localparam logic [4:0] M = 5'b00011;
  localparam logic [4:0] R = 5'b00110;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mr;
    logic [4:0] ert;
    logic       br;
    logic       md;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic urs,
                              logic urt, logic mr, logic [4:0] ert, logic br,
                              logic md, logic [4:0] exp);
    vec_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.mr = mr; v.ert = ert; v.br = br; v.md = md; v.exp = exp;
    return v;
  endfunction

  task automatic check16(string name, logic [15:0] got, logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    vec_t       e;
    logic [4:0] got;
    logic [15:0] exp_stall;
    logic        stall_known;

    rst = 1'b1; rst2 = 1'b1; md_start2 = 1'b0;
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rs = 0; id_uses_rt = 0; ex_memread = 0; branch_taken = 0; md_start = 0;
    exp_stall = '0; stall_known = 1'b0;

    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, R));  // reset outputs
    vecs.push_back(mk(0, 1, 2, 1, 1, 0, 0, 0, 0, N));  // plain run
    vecs.push_back(mk(0, 5, 2, 1, 0, 1, 5, 0, 0, S));  // load-use on rs
    vecs.push_back(mk(0, 5, 2, 1, 0, 1, 5, 0, 0, N));  // LDSTALL suppresses hazard
    vecs.push_back(mk(0, 0, 3, 1, 0, 1, 0, 0, 0, N));  // $zero never stalls
    vecs.push_back(mk(0, 5, 3, 0, 0, 1, 5, 0, 0, N));  // rs not read
    vecs.push_back(mk(0, 1, 7, 0, 1, 1, 7, 0, 0, S));  // load-use on rt
    vecs.push_back(mk(0, 1, 7, 0, 1, 1, 7, 1, 0, B));  // branch in LDSTALL
    vecs.push_back(mk(0, 5, 7, 1, 1, 1, 5, 1, 1, B));  // branch beats hazard+md
    vecs.push_back(mk(0, 5, 7, 1, 1, 0, 5, 0, 0, N));  // still RUN, not MDWAIT
    vecs.push_back(mk(0, 3, 4, 1, 1, 0, 0, 0, 1, N));  // md_start advances
    vecs.push_back(mk(0, 3, 4, 1, 1, 0, 0, 0, 0, M));
    vecs.push_back(mk(0, 3, 4, 1, 1, 0, 0, 1, 0, M));  // branch ignored
    vecs.push_back(mk(0, 3, 4, 1, 1, 1, 3, 0, 0, M));  // hazard ignored
    vecs.push_back(mk(0, 3, 4, 1, 1, 0, 0, 0, 1, M));  // md_start ignored
    vecs.push_back(mk(0, 3, 4, 1, 1, 0, 0, 0, 0, N));  // exactly 4 stall cycles
    vecs.push_back(mk(0, 9, 4, 1, 0, 1, 9, 0, 0, S));
    vecs.push_back(mk(0, 9, 4, 1, 0, 1, 9, 0, 1, N));  // md_start from LDSTALL
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, M));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, R));  // reset mid-MDWAIT
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N));
    vecs.push_back(mk(0, 6, 0, 1, 0, 1, 6, 0, 0, S));
    vecs.push_back(mk(1, 6, 0, 1, 0, 1, 6, 0, 0, R));  // reset in LDSTALL
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, N));  // counter restarts full
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, M));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, M));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, M));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, M));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, N));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
      ex_memread = vecs[i].mr; ex_rt = vecs[i].ert;
      branch_taken = vecs[i].br; md_start = vecs[i].md;
      sb_q.push_back(vecs[i]);
      #1;
      e = sb_q.pop_front();
      got = {pc_en, ifid_en, ifid_flush, idex_bubble, md_busy};
      tests++;
      if (got !== e.exp) begin
        fails++;
        $display("FAIL vec%0d outputs got=%b exp=%b", i, got, e.exp);
      end
      tests++;
      if (ifid_flush && !ifid_en && !rst) begin
        fails++;
        $display("FAIL vec%0d flush_without_load got=1 exp=0", i);
      end
      if (stall_known) check16($sformatf("vec%0d stall_count", i), stall_count, exp_stall);
      if (e.rst) begin
        exp_stall   = '0;
        stall_known = 1'b1;
      end else if (!e.exp[4] && exp_stall != 16'hFFFF) begin
        exp_stall = exp_stall + 16'd1;
      end
    end

    // Saturation on the MD_LAT=64 instance with md_start held high
    @(negedge clk);
    rst = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rs = 0; id_uses_rt = 0; ex_memread = 0; branch_taken = 0; md_start = 0;
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0; md_start2 = 1'b1;
    repeat (64) @(negedge clk);
    check16("md64 last_stall_cycle", {11'd0, pc_en2, ifid_en2, ifid_flush2, idex_bubble2, md_busy2},
            {11'd0, M});
    check16("md64 stall_at_63", stall_count2, 16'd63);
    @(negedge clk);
    check16("md64 back_to_run", {11'd0, pc_en2, ifid_en2, ifid_flush2, idex_bubble2, md_busy2},
            {11'd0, N});
    check16("md64 stall_at_64", stall_count2, 16'd64);
    repeat (71200) @(negedge clk);
    check16("sat reached", stall_count2, 16'hFFFF);
    repeat (300) @(negedge clk);
    check16("sat holds", stall_count2, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
